// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the limb-serial wide adder sequencer.
package wide_add_pkg;
  localparam int LIMB_W    = 32;
  // Upper bound on NLIMBS supported by limb_sel's fixed-width argument.
  localparam int MAX_LIMBS = 64;

  typedef logic [LIMB_W-1:0] limb_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic limb_t limb_sel(input logic [MAX_LIMBS*LIMB_W-1:0] vec,
                                     input int unsigned idx);
    limb_sel = '0;
    if (idx < MAX_LIMBS) limb_sel = vec[idx*LIMB_W +: LIMB_W];
  endfunction
endpackage

// File: rtl/wide_add_limb_sel.sv
// Combinational limb picker: limb idx of A and B, with B optionally
// one's-complemented so the external adder can perform subtraction.
module wide_add_limb_sel
  import wide_add_pkg::*;
#(
  parameter int NLIMBS = 4,
  parameter int IDX_W  = $clog2(NLIMBS)
) (
  input  logic [NLIMBS*LIMB_W-1:0] a_vec,
  input  logic [NLIMBS*LIMB_W-1:0] b_vec,
  input  logic [IDX_W-1:0]         idx,
  input  logic                     inv,
  output logic [LIMB_W-1:0]        limb_a,
  output logic [LIMB_W-1:0]        limb_b
);
  localparam int W = NLIMBS*LIMB_W;

  logic [MAX_LIMBS*LIMB_W-1:0] a_ext;
  logic [MAX_LIMBS*LIMB_W-1:0] b_ext;

  always_comb begin
    a_ext         = '0;
    b_ext         = '0;
    a_ext[W-1:0]  = a_vec;
    b_ext[W-1:0]  = b_vec;
    limb_a        = limb_sel(a_ext, 32'(idx));
    limb_b        = limb_sel(b_ext, 32'(idx)) ^ {LIMB_W{inv}};
  end
endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add sequencer: feeds an external 32-bit adder one limb per
// cycle, LS first, chaining carries. Optional subtract via WIDE_ADD_SUB_EN.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int NLIMBS = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [NLIMBS*LIMB_W-1:0] OpA,
  input  logic [NLIMBS*LIMB_W-1:0] OpB,
  input  logic                     Cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                     Sub,
`endif
  output logic [LIMB_W-1:0]        AdderA,
  output logic [LIMB_W-1:0]        AdderB,
  output logic                     AdderCin,
  input  logic [LIMB_W:0]          AdderS,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [NLIMBS*LIMB_W-1:0] Sum,
  output logic                     Cout
);
  localparam int W     = NLIMBS*LIMB_W;
  localparam int IDX_W = $clog2(NLIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS-1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             inv;
  logic [LIMB_W-1:0] sel_a, sel_b;

`ifdef WIDE_ADD_SUB_EN
  logic sub_q, sub_d;
  assign inv = sub_q;
`else
  assign inv = 1'b0;
`endif

  wide_add_limb_sel #(.NLIMBS(NLIMBS), .IDX_W(IDX_W)) u_limb_sel (
    .a_vec  (a_q),
    .b_vec  (b_q),
    .idx    (idx_q),
    .inv    (inv),
    .limb_a (sel_a),
    .limb_b (sel_b)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef WIDE_ADD_SUB_EN
    sub_d    = sub_q;
`endif
    InReady  = 1'b0;
    OutValid = 1'b0;
    AdderA   = '0;
    AdderB   = '0;
    AdderCin = 1'b0;
    unique case (state_q)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) begin
          a_d     = OpA;
          b_d     = OpB;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
`ifdef WIDE_ADD_SUB_EN
          sub_d   = Sub;
          // A - B = A + ~B + 1, so the caller's Cin is overridden.
          carry_d = Sub ? 1'b1 : Cin;
`else
          carry_d = Cin;
`endif
        end
      end
      RUN: begin
        AdderA   = sel_a;
        AdderB   = sel_b;
        AdderCin = carry_q;
        sum_d[idx_q*LIMB_W +: LIMB_W] = AdderS[LIMB_W-1:0];
        carry_d  = AdderS[LIMB_W];
        if (idx_q == LAST_IDX) begin
          cout_d  = AdderS[LIMB_W];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Nothing handshakes or drives the adder while reset is asserted.
    if (Rst) begin
      InReady  = 1'b0;
      OutValid = 1'b0;
      AdderA   = '0;
      AdderB   = '0;
      AdderCin = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef WIDE_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
endmodule
